// File: rtl/opm_sched_pkg.sv
// Shared types and default pacing constants for the OPM write scheduler.
package opm_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP,
        ST_DATA,
        ST_WAIT
    } opm_state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } opm_pair_t;

    localparam int DEF_ADDR_GAP  = 2;
    localparam int DEF_DATA_WAIT = 68;

endpackage

// File: rtl/opm_sched_fifo.sv
// DEPTH-entry FIFO of {register, data} pairs; a push while full is taken when a pop frees a slot.
module opm_sched_fifo
    import opm_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  opm_pair_t                wdata_i,
    input  logic                     pop_i,
    output opm_pair_t                rdata_o,
    output logic                     accept_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    opm_pair_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            do_pop;

    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign do_pop   = pop_i && !empty_o;
    assign accept_o = push_i && (!full_o || do_pop);
    assign rdata_o  = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        case ({accept_o, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept_o) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Full push+pop shares a slot: the read side sees the old entry this cycle.
    always_ff @(posedge clk) begin
        if (accept_o) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/opm_write_scheduler.sv
// Buffers CPU {register, data} writes and replays them to a jt51 with ce-tick spacing.
module opm_write_scheduler
    import opm_sched_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_GAP  = DEF_ADDR_GAP,
    parameter int DATA_WAIT = DEF_DATA_WAIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic       cpu_a0,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       opm_cs_n,
    output logic       opm_wr_n,
    output logic       opm_a0,
    output logic [7:0] opm_din,
    input  logic [7:0] opm_dout,
    output logic       overflow,
    output logic       idle
);
    localparam int CNT_MAX = (ADDR_GAP > DATA_WAIT) ? ADDR_GAP : DATA_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int QW      = $clog2(DEPTH) + 1;

    opm_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    opm_pair_t       pair_q, pair_d, fifo_rdata;
    logic [7:0]      din_q, din_d, latch_q;
    logic            overflow_q;
    logic            push, pop, accept, full, empty, strobe, status_rd;
    logic [QW-1:0]   count;

    assign push      = cpu_wr && cpu_a0;
    assign strobe    = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign status_rd = cpu_rd && !cpu_a0 && !strobe;

    opm_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (push),
        .wdata_i  ('{reg_addr: latch_q, data: cpu_din}),
        .pop_i    (pop),
        .rdata_o  (fifo_rdata),
        .accept_o (accept),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        din_d   = din_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: pop = !empty;
            ST_ADDR: begin
                cnt_d   = CW'(ADDR_GAP);
                state_d = ST_GAP;
            end
            ST_GAP: if (ce && cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DATA;
                    din_d   = pair_q.data;
                end
            end
            ST_DATA: begin
                cnt_d   = CW'(DATA_WAIT);
                state_d = ST_WAIT;
            end
            ST_WAIT: if (ce && cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    pop     = !empty;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Popping always starts a new pair; the register byte drives the bus during ADDR.
        if (pop) begin
            state_d = ST_ADDR;
            pair_d  = fifo_rdata;
            din_d   = fifo_rdata.reg_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pair_q     <= '0;
            din_q      <= '0;
            latch_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            din_q   <= din_d;
            if (cpu_wr && !cpu_a0) latch_q <= cpu_din;
            if (push && !accept)   overflow_q <= 1'b1;
            else if (status_rd)    overflow_q <= 1'b0;
        end
    end

    assign opm_wr_n = !strobe;
    assign opm_a0   = (state_q == ST_DATA);
    assign opm_cs_n = strobe ? 1'b0 : !cpu_rd;
    assign opm_din  = din_q;
    assign cpu_dout = status_rd ? {full, opm_dout[6:0]} : 8'hFF;
    assign overflow = overflow_q;
    assign idle     = (count == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_opm_write_scheduler.sv
// Scoreboarded bench: stimulus queues expected pairs, a monitor checks every OPM write strobe.
module tb_opm_write_scheduler;
    import opm_sched_pkg::*;

    localparam int DEPTH     = 16;
    localparam int ADDR_GAP  = 2;
    localparam int DATA_WAIT = 68;

    logic       clk = 1'b0, reset = 1'b1;
    logic       ce;
    logic       cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_a0 = 1'b0;
    logic [7:0] cpu_din = 8'h00, opm_dout = 8'h00;
    logic [7:0] cpu_dout, opm_din;
    logic       opm_cs_n, opm_wr_n, opm_a0, overflow, idle;
    logic [1:0] cediv = 2'd0;

    int         checks = 0, errors = 0;
    opm_pair_t  sb[$];
    bit         got_addr = 1'b0;

    opm_write_scheduler #(.DEPTH(DEPTH), .ADDR_GAP(ADDR_GAP), .DATA_WAIT(DATA_WAIT)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_a0(cpu_a0), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout),
        .opm_cs_n(opm_cs_n), .opm_wr_n(opm_wr_n), .opm_a0(opm_a0), .opm_din(opm_din),
        .opm_dout(opm_dout), .overflow(overflow), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cediv <= (cediv == 2'd2) ? 2'd0 : cediv + 2'd1;
    assign ce = (cediv == 2'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, expected event", name);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic wr(input logic a0, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_a0 = a0; cpu_din = d;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_a0 = 1'b0;
    endtask

    task automatic wr_pair(input logic [7:0] r, input logic [7:0] d, input bit accepted);
        wr(1'b0, r);
        wr(1'b1, d);
        if (accepted) sb.push_back('{reg_addr: r, data: d});
    endtask

    task automatic wait_strobe(input logic a0v, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (!opm_wr_n && opm_a0 == a0v) found = 1'b1;
        end
        if (!found) timeout_fail(name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (idle) found = 1'b1;
        end
        if (!found) timeout_fail(name);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            sb.delete();
            got_addr = 1'b0;
        end else if (!opm_wr_n) begin
            if (sb.size() == 0) begin
                timeout_fail($sformatf("unexpected_strobe a0=%0d din=%0h", opm_a0, opm_din));
            end else if (!opm_a0) begin
                chk("opm_addr_byte", opm_din, sb[0].reg_addr);
                chk("opm_cs_n_on_write", opm_cs_n, 1'b0);
                got_addr = 1'b1;
            end else begin
                chk("opm_addr_before_data", got_addr, 1'b1);
                chk("opm_data_byte", opm_din, sb[0].data);
                void'(sb.pop_front());
                got_addr = 1'b0;
            end
        end
    end

    initial begin
        int  k;
        bit  found;

        // Reset values
        @(negedge clk); #1;
        chk("rst_cs_n", opm_cs_n, 1'b1);
        chk("rst_wr_n", opm_wr_n, 1'b1);
        chk("rst_a0", opm_a0, 1'b0);
        chk("rst_din", opm_din, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_cpu_dout", cpu_dout, 8'hFF);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // Single pair: latency and ce spacing
        wr(1'b0, 8'h20);
        wr(1'b1, 8'hC7);
        sb.push_back('{reg_addr: 8'h20, data: 8'hC7});
        chk("entry_visible_T1", idle, 1'b0);
        chk("no_strobe_T1", opm_wr_n, 1'b1);
        @(negedge clk);
        chk("addr_strobe_T2", {opm_wr_n, opm_a0}, 2'b00);
        chk("addr_din_T2", opm_din, 8'h20);
        k = 0; found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (!opm_wr_n && opm_a0) found = 1'b1;
            else if (ce) k++;
        end
        chk("gap_ce_ticks", k, ADDR_GAP);
        k = 0; found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (idle) found = 1'b1;
            else if (ce) k++;
        end
        chk("wait_ce_ticks", k, DATA_WAIT);

        // Burst of 20 while the drain is busy: 16 fit, 4 dropped
        wr_pair(8'h10, 8'h11, 1'b1);
        wait_strobe(1'b1, "prime_data_strobe");
        for (int i = 0; i < 20; i++)
            wr_pair(8'h40 + 8'(i), 8'hA0 + 8'(i), i < DEPTH);
        #1;
        chk("overflow_set", overflow, 1'b1);
        opm_dout = 8'h00; cpu_rd = 1'b1; cpu_a0 = 1'b0; #1;
        chk("status_full_bit", cpu_dout, 8'h80);
        chk("overflow_held_during_read", overflow, 1'b1);
        @(negedge clk); cpu_rd = 1'b0; #1;
        chk("overflow_cleared", overflow, 1'b0);

        // Refill to full, then push on the cycle of the pop from full
        wait_strobe(1'b0, "b0_addr_strobe");
        wr_pair(8'h55, 8'hAA, 1'b1);
        wait_strobe(1'b1, "b0_data_strobe");
        cpu_wr = 1'b1; cpu_a0 = 1'b0; cpu_din = 8'h66;
        k = 0;
        for (int i = 0; i < 1000 && k < DATA_WAIT; i++) begin
            @(negedge clk);
            cpu_wr = 1'b0;
            if (ce) k++;
        end
        chk("wait_ce_before_pop", k, DATA_WAIT);
        cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_din = 8'h99;
        sb.push_back('{reg_addr: 8'h66, data: 8'h99});
        @(negedge clk);
        cpu_wr = 1'b0; cpu_a0 = 1'b0;
        chk("pop_full_addr_strobe", {opm_wr_n, opm_a0}, 2'b00);
        chk("pop_full_no_overflow", overflow, 1'b0);
        cpu_rd = 1'b1; #1;
        chk("read_during_addr", cpu_dout, 8'hFF);
        chk("read_during_addr_cs_n", opm_cs_n, 1'b0);
        @(negedge clk); opm_dout = 8'h83; #1;
        chk("count_stays_full", cpu_dout, 8'h83);
        cpu_rd = 1'b0;
        wait_idle(8000, "burst_drain_idle");
        chk("burst_all_replayed", sb.size(), 0);

        // Reset asserted during GAP with another pair queued
        @(negedge clk);
        wr_pair(8'h30, 8'h31, 1'b1);
        wr_pair(8'h40, 8'h41, 1'b0);
        #2 reset = 1'b1; #1;
        chk("gap_rst_wr_n", opm_wr_n, 1'b1);
        chk("gap_rst_cs_n", opm_cs_n, 1'b1);
        chk("gap_rst_a0", opm_a0, 1'b0);
        chk("gap_rst_din", opm_din, 8'h00);
        chk("gap_rst_idle", idle, 1'b1);
        chk("gap_rst_overflow", overflow, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) @(negedge clk);
        chk("gap_rst_fifo_empty", idle, 1'b1);

        // Pointer wrap: 40 pairs, each issued after idle
        for (int i = 0; i < 40; i++) begin
            wr_pair(8'h80 + 8'(i), 8'(i * 5 + 1), 1'b1);
            if (i == 0) begin
                wait_strobe(1'b1, "wrap0_data_strobe");
                @(negedge clk);
                opm_dout = 8'h83; cpu_rd = 1'b1; cpu_a0 = 1'b0; #1;
                chk("wait_read_dout", cpu_dout, 8'h03);
                chk("wait_read_cs_n", opm_cs_n, 1'b0);
                chk("wait_read_wr_n", opm_wr_n, 1'b1);
                chk("wait_read_a0", opm_a0, 1'b0);
                cpu_rd = 1'b0;
            end
            wait_idle(1000, "wrap_idle");
        end
        chk("wrap_all_replayed", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
